// File: rtl/vr16_pkg.sv
// Shared definitions for the vr16 register-file read path: data width,
// register encodings and the operand stage state type.
package vr16_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [1:0] REG_A = 2'b00;
  localparam logic [1:0] REG_B = 2'b01;
  localparam logic [1:0] REG_C = 2'b10;
  localparam logic [1:0] REG_D = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

endpackage : vr16_pkg

// File: rtl/operand_select.sv
// 4:1 register mux with same-edge writeback bypass, one per source operand.
module operand_select
  import vr16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] reg_c,
  input  logic [WIDTH-1:0] reg_d,
  input  logic             wb_enable,
  input  logic [1:0]       wb_select,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] operand
);

  logic [WIDTH-1:0] mux_s;

  // Register mux, then a writeback landing on the same register overrides it
  always_comb begin
    mux_s = reg_a;
    case (sel)
      REG_A:   mux_s = reg_a;
      REG_B:   mux_s = reg_b;
      REG_C:   mux_s = reg_c;
      REG_D:   mux_s = reg_d;
      default: mux_s = reg_a;
    endcase
    if (wb_enable && (wb_select == sel)) begin
      operand = wb_data;
    end else begin
      operand = mux_s;
    end
  end

endmodule : operand_select

// File: rtl/operand_read_unit.sv
// Single-entry operand stage between decode and the ALU; held operands track
// later writebacks to their source registers while stalled.
module operand_read_unit
  import vr16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       src_a_sel,
  input  logic [1:0]       src_b_sel,
  input  logic [1:0]       dst_sel,
  input  logic [WIDTH-1:0] reg_a_out,
  input  logic [WIDTH-1:0] reg_b_out,
  input  logic [WIDTH-1:0] reg_c_out,
  input  logic [WIDTH-1:0] reg_d_out,
  input  logic             wb_enable,
  input  logic [1:0]       wb_select,
  input  logic [WIDTH-1:0] wb_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       op_dst
);

  stage_state_t     state_r;
  logic [1:0]       sel_a_r;
  logic [1:0]       sel_b_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [1:0]       op_dst_r;
  logic [WIDTH-1:0] load_a_s;
  logic [WIDTH-1:0] load_b_s;
  logic             accept_s;

  operand_select #(.WIDTH(WIDTH)) u_sel_a (
    .sel       (src_a_sel),
    .reg_a     (reg_a_out),
    .reg_b     (reg_b_out),
    .reg_c     (reg_c_out),
    .reg_d     (reg_d_out),
    .wb_enable (wb_enable),
    .wb_select (wb_select),
    .wb_data   (wb_data),
    .operand   (load_a_s)
  );

  operand_select #(.WIDTH(WIDTH)) u_sel_b (
    .sel       (src_b_sel),
    .reg_a     (reg_a_out),
    .reg_b     (reg_b_out),
    .reg_c     (reg_c_out),
    .reg_d     (reg_d_out),
    .wb_enable (wb_enable),
    .wb_select (wb_select),
    .wb_data   (wb_data),
    .operand   (load_b_s)
  );

  // Ready is combinational so a draining entry can be replaced in the same cycle
  assign req_ready = !reset && ((state_r == EMPTY) || op_ready);
  assign accept_s  = req_valid && req_ready;

  assign op_valid = (state_r == FULL);
  assign op_a     = op_a_r;
  assign op_b     = op_b_r;
  assign op_dst   = op_dst_r;

  // Stage FSM with load, drain and stall-time refresh of the held operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= EMPTY;
      sel_a_r  <= REG_A;
      sel_b_r  <= REG_A;
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      op_dst_r <= 2'b00;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r  <= FULL;
            sel_a_r  <= src_a_sel;
            sel_b_r  <= src_b_sel;
            op_a_r   <= load_a_s;
            op_b_r   <= load_b_s;
            op_dst_r <= dst_sel;
          end else begin
            state_r <= EMPTY;
          end
        end
        FULL: begin
          if (op_ready) begin
            if (accept_s) begin
              state_r  <= FULL;
              sel_a_r  <= src_a_sel;
              sel_b_r  <= src_b_sel;
              op_a_r   <= load_a_s;
              op_b_r   <= load_b_s;
              op_dst_r <= dst_sel;
            end else begin
              state_r <= EMPTY;
            end
          end else begin
            // Stalled: keep the held copy equal to the register it came from
            state_r <= FULL;
            if (wb_enable && (wb_select == sel_a_r)) begin
              op_a_r <= wb_data;
            end else begin
              op_a_r <= op_a_r;
            end
            if (wb_enable && (wb_select == sel_b_r)) begin
              op_b_r <= wb_data;
            end else begin
              op_b_r <= op_b_r;
            end
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

endmodule : operand_read_unit
